// File: rtl/alu_mips_pkg.sv
// ============================================================================
// Module      : alu_mips_pkg
// Description : Shared widths, MIPS ALU ctl encodings and flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_mips_pkg;

    localparam int ALU_W   = 32;
    localparam int OPCTL_W = 11;
    localparam int CTL_W   = 6;
    localparam int SHAMT_W = 5;
    localparam int FLAG_W  = 3;

    localparam logic [CTL_W-1:0] CTL_SLL  = 6'b000000;
    localparam logic [CTL_W-1:0] CTL_SRL  = 6'b000010;
    localparam logic [CTL_W-1:0] CTL_ADD  = 6'b100000;
    localparam logic [CTL_W-1:0] CTL_SUB  = 6'b100010;
    localparam logic [CTL_W-1:0] CTL_AND  = 6'b100100;
    localparam logic [CTL_W-1:0] CTL_OR   = 6'b100101;
    localparam logic [CTL_W-1:0] CTL_XOR  = 6'b100110;
    localparam logic [CTL_W-1:0] CTL_NOR  = 6'b100111;
    localparam logic [CTL_W-1:0] CTL_SLT  = 6'b101010;
    localparam logic [CTL_W-1:0] CTL_SLTU = 6'b101011;

    // Positions inside the {overflow, carryout, zero} response flag field
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search starts at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W:0] w_cand;
    logic           w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < N; k++) begin
            // ptr is always below N, so one conditional subtract wraps it
            w_cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(N)) begin
                w_cand = w_cand - (IDX_W+1)'(N);
            end
            if (!w_found && eligible[w_cand[IDX_W-1:0]]) begin
                w_found                     = 1'b1;
                grant[w_cand[IDX_W-1:0]]    = 1'b1;
                grant_idx                   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_mips_rr_sched.sv
// ============================================================================
// Module      : alu_mips_rr_sched
// Description : Shares one MIPS ALU among N_REQ requesters, round-robin issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mips_rr_sched
    import alu_mips_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [ALU_W*N_REQ-1:0]     req_a,
    input  logic [ALU_W*N_REQ-1:0]     req_b,
    input  logic [OPCTL_W*N_REQ-1:0]   req_op_ctl,
    output logic [N_REQ-1:0]           rsp_valid,
    input  logic [N_REQ-1:0]           rsp_ready,
    output logic [ALU_W*N_REQ-1:0]     rsp_z,
    output logic [FLAG_W*N_REQ-1:0]    rsp_flags,
    output logic [ALU_W-1:0]           alu_a,
    output logic [ALU_W-1:0]           alu_b,
    output logic [OPCTL_W-1:0]         alu_op_ctl,
    input  logic [ALU_W-1:0]           alu_z,
    input  logic                       alu_overflow,
    input  logic                       alu_carryout,
    input  logic                       alu_zero
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   r_busy;
    logic [N_REQ-1:0]   w_eligible;
    logic [N_REQ-1:0]   w_grant;
    logic [N_REQ-1:0]   w_drain;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_any_grant;

    logic               r_s1_valid;
    logic [IDX_W-1:0]   r_s1_idx;
    logic [ALU_W-1:0]   r_s1_a;
    logic [ALU_W-1:0]   r_s1_b;
    logic [OPCTL_W-1:0] r_s1_op;

    logic [ALU_W-1:0]   w_a  [N_REQ];
    logic [ALU_W-1:0]   w_b  [N_REQ];
    logic [OPCTL_W-1:0] w_op [N_REQ];
    logic [FLAG_W-1:0]  w_flags;

    // Gating with rst_n keeps req_ready low while reset is held
    assign w_eligible  = req_valid & ~r_busy & {N_REQ{rst_n}};
    assign w_any_grant = |w_grant;
    assign req_ready   = w_grant;
    assign w_drain     = rsp_valid & rsp_ready;

    assign alu_a      = r_s1_a;
    assign alu_b      = r_s1_b;
    assign alu_op_ctl = r_s1_op;

    always_comb begin
        w_flags             = '0;
        w_flags[FLAG_OVF]   = alu_overflow;
        w_flags[FLAG_CARRY] = alu_carryout;
        w_flags[FLAG_ZERO]  = alu_zero;
    end

    rr_arbiter #(
        .N         (N_REQ)
    ) u_arb (
        .eligible  (w_eligible),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
        end else begin
            r_busy     <= (r_busy & ~w_drain) | w_grant;
            r_s1_valid <= w_any_grant;
            if (w_any_grant) begin
                r_ptr    <= (w_grant_idx == IDX_W'(N_REQ-1)) ? '0 : w_grant_idx + IDX_W'(1);
                r_s1_idx <= w_grant_idx;
                r_s1_a   <= w_a[w_grant_idx];
                r_s1_b   <= w_b[w_grant_idx];
                r_s1_op  <= w_op[w_grant_idx];
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        logic              r_valid;
        logic [ALU_W-1:0]  r_z;
        logic [FLAG_W-1:0] r_flags;
        logic              w_capture;

        assign w_a[i]  = req_a[i*ALU_W +: ALU_W];
        assign w_b[i]  = req_b[i*ALU_W +: ALU_W];
        assign w_op[i] = req_op_ctl[i*OPCTL_W +: OPCTL_W];

        assign w_capture = r_s1_valid && (r_s1_idx == IDX_W'(i));

        // busy guarantees capture and drain never target the same full slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_z     <= '0;
                r_flags <= '0;
            end else if (w_capture) begin
                r_valid <= 1'b1;
                r_z     <= alu_z;
                r_flags <= w_flags;
            end else if (w_drain[i]) begin
                r_valid <= 1'b0;
            end
        end

        assign rsp_valid[i]                   = r_valid;
        assign rsp_z[i*ALU_W +: ALU_W]        = r_z;
        assign rsp_flags[i*FLAG_W +: FLAG_W]  = r_flags;
    end

endmodule

`default_nettype wire

// File: doc/alu_mips_rr_sched.md
Name: alu_mips_rr_sched

Overview:
Round-robin scheduler that shares one combinational 32b MIPS ALU instance (A, B, 11b op_ctl in; Z, overflow, zero, carryout out) among N_REQ requesters. Each requester has a valid/ready request channel and a one-entry valid/ready response channel. Operands are registered before driving the ALU, and the ALU result is captured one cycle later into the response slot of the requester that issued it. The block sits between CPU-side issue ports (e.g. integer pipes, address-gen unit) and the single ALU.

Parameters:
N_REQ, 4, number of requesters; legal range 2..8.

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  request valid, one bit per requester
req_ready  out  N_REQ  request accepted when valid&ready
req_a  in  32*N_REQ  operand A, requester i at [32i+31:32i]
req_b  in  32*N_REQ  operand B, same packing
req_op_ctl  in  11*N_REQ  {shamt[4:0], ctl[5:0]} per requester
rsp_valid  out  N_REQ  response slot full
rsp_ready  in  N_REQ  response consumed when valid&ready
rsp_z  out  32*N_REQ  result per requester
rsp_flags  out  3*N_REQ  {overflow, carryout, zero} per requester
alu_a  out  32  to ALU A
alu_b  out  32  to ALU B
alu_op_ctl  out  11  to ALU op_ctl
alu_z  in  32  from ALU Z
alu_overflow  in  1  from ALU
alu_carryout  in  1  from ALU
alu_zero  in  1  from ALU

Behaviour:
- Reset (rst_n low, async): req_ready=0, rsp_valid=0, rsp_z=0, rsp_flags=0, alu_a/alu_b/alu_op_ctl=0, busy=0, S1 valid=0, rr pointer=0. Any in-flight op is discarded; no response is produced for it.
- busy[i]: set on grant to i; cleared on rsp handshake of i. One outstanding op per requester.
- Eligible[i] = req_valid[i] & ~busy[i]. busy is registered, so a requester whose response drains in cycle t is eligible again in cycle t+1, never in t.
- Arbitration is combinational, at most one grant per cycle. Search starts at ptr and wraps modulo N_REQ. req_ready = one-hot grant; req_ready never asserts for a non-eligible requester.
- ptr update on grant to i: ptr <= (i+1) mod N_REQ. ptr holds when there is no grant.
- S1 (issue reg): on grant, latches operands, op_ctl and requester index, and S1 valid <= 1; otherwise S1 valid <= 0. alu_a, alu_b and alu_op_ctl are driven directly from the S1 regs and hold their last values when S1 is empty.
- S2 (capture): if S1 valid, rsp_z[idx] <= alu_z, rsp_flags[idx] <= {alu_overflow, alu_carryout, alu_zero}, rsp_valid[idx] <= 1.
- Latency: handshake at edge t produces rsp_valid at t+2. Throughput: 1 op/cycle aggregate; per requester, 1 op per 3 cycles minimum (grant, capture, drain, then eligible).
- rsp slot holds stable while rsp_valid & ~rsp_ready. Because busy bounds outstanding ops to one, the slot can never be overwritten.
- op_ctl is passed through unchecked. Flags are the ALU's raw outputs for every op class, including shifts and logic ops.
- Simultaneous response drains and a new grant to different requesters in the same cycle are independent and both occur.

Decomposition:
- Package alu_mips_pkg: ALU_W=32, OPCTL_W=11, CTL_W=6, SHAMT_W=5. ctl encodings: CTL_SLL=6'b000000, CTL_SRL=6'b000010, CTL_ADD=6'b100000, CTL_SUB=6'b100010, CTL_AND=6'b100100, CTL_OR=6'b100101, CTL_XOR=6'b100110, CTL_NOR=6'b100111, CTL_SLT=6'b101010, CTL_SLTU=6'b101011. Flag bit index constants.
- One sub-module: rr_arbiter (parameter N; ports: eligible, ptr, grant one-hot, grant index). Combinational and reused elsewhere; the ptr register lives in the parent.

Test Plan:
- Single op, req0: A=5, B=7, CTL_ADD. Expect req_ready[0] same cycle, rsp_valid[0] at t+2, rsp_z=12, flags=3'b000 (plus whatever carryout the ALU reports).
- req2: A=B=0x1234, CTL_SUB -> rsp_z=0, zero=1. req1: A=0x7FFFFFFF, B=1, CTL_ADD -> rsp_z=0x80000000, overflow=1.
- All four requesters valid from reset with rsp_ready=1 -> grants 0,1,2,3 on consecutive cycles, then 0 again after busy[0] clears; no requester starved.
- Backpressure: rsp_ready[1]=0 for 10 cycles with req1 valid -> exactly one grant to req1; others keep issuing; rsp_z[1] stable; req1 re-granted the cycle after its drain, not the same cycle.
- Shift: req3 op_ctl={5'd4, CTL_SLL}, A=0x1 -> rsp_z=0x10; {5'd4, CTL_SRL}, A=0x100 -> 0x10. CTL_SLT with A=-1, B=1 -> 1; CTL_SLTU -> 0.
- Async reset asserted one cycle after a grant (S1 valid) -> all rsp_valid=0 immediately, no response after release, ptr=0, first grant after release goes to req0.
